seq_alu: RTL

Parametrised multi-cycle successor to the team's combinational 8-op ALU. It adds a valid/ready handshake, an iterative shift-add multiplier with full-width overflow detection, and a restoring signed divider (optional). Status flags are fully defined, with no z outputs. It sits between the operand register file and the writeback stage and accepts one operation at a time.

---
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake/data bundle between the operand register file, seq_alu and writeback.
// The master side issues operations and consumes results; the slave side is the ALU.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_zero;
   logic             flag_ovf;
   logic             flag_neg;
   logic             flag_ill;

   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_ovf, flag_neg, flag_ill
   );

   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_ovf, flag_neg, flag_ill
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU with valid/ready handshake.
// Single-cycle ops: SLA, SRA, ADD, SUB, AND, OR, NOT. Iterative ops: MUL (shift-add),
// and DIV/REM (restoring) when the SEQ_ALU_DIV_EN macro is defined. Without that macro
// opcodes 8/9 are reported as illegal and no divider hardware exists.
// One operation is in flight at a time; results are held until the consumer takes them.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_SLA = 4'd0;
   localparam logic [3:0] OP_SRA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_MUL = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [3:0] OP_DIV = 4'd8;
   localparam logic [3:0] OP_REM = 4'd9;
`endif

`ifdef SEQ_ALU_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
`else
   typedef enum logic [1:0] {IDLE, MUL, DONE} stateT;
`endif

   stateT              state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               negRes_q, negRes_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               ill_q, ill_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;

   logic               accept;
   logic               lastIter;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH-1:0]   sum, diff;
   logic [2*WIDTH-1:0] mulAccNext;
   logic [WIDTH-1:0]   mulLow;
   logic               mulOvf;

   logic               load;
   logic [WIDTH-1:0]   newRes;
   logic               newOvf;
   logic               newIll;

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [WIDTH-1:0]   dividend_q, dividend_d;
   logic               isRem_q, isRem_d;
   logic               divOvf_q, divOvf_d;
   logic [WIDTH:0]     divShift, divTrial;
   logic               divBit;
   logic               divZero;
   logic [WIDTH-1:0]   quoNext, remNext, quoOut, remOut;
`endif

   assign accept   = bus.in_valid & bus.in_ready;
   assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));
   assign absA     = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign absB     = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign sum      = bus.a + bus.b;
   assign diff     = bus.a - bus.b;

   // Magnitude product grows by one partial product per cycle; the signed view and its
   // overflow test are taken from the value about to be written on the last iteration.
   assign mulAccNext = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mulLow     = negRes_q ? -mulAccNext[WIDTH-1:0] : mulAccNext[WIDTH-1:0];
   assign mulOvf     = negRes_q
                       ? ((|mulAccNext[2*WIDTH-1:WIDTH]) |
                          (mulAccNext[WIDTH-1] & (|mulAccNext[WIDTH-2:0])))
                       : (|mulAccNext[2*WIDTH-1:WIDTH-1]);

`ifdef SEQ_ALU_DIV_EN
   // Restoring step: shift the next dividend bit into the partial remainder and keep the
   // trial subtraction only when it does not borrow.
   assign divShift = {rem_q, quo_q[WIDTH-1]};
   assign divTrial = divShift - {1'b0, divisor_q};
   assign divBit   = ~divTrial[WIDTH];
   assign remNext  = divBit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
   assign quoNext  = {quo_q[WIDTH-2:0], divBit};
   assign divZero  = (divisor_q == '0);
   assign quoOut   = divZero ? '1 : (negRes_q ? -quoNext : quoNext);
   assign remOut   = divZero ? dividend_q : (dividend_q[WIDTH-1] ? -remNext : remNext);
`endif

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: single-cycle ops go straight to DONE, iterative ops count WIDTH steps.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.opcode == OP_MUL) state_d = MUL;
`ifdef SEQ_ALU_DIV_EN
               else if ((bus.opcode == OP_DIV) || (bus.opcode == OP_REM)) state_d = DIV;
`endif
               else state_d = DONE;
            end
         end
         MUL: if (lastIter) state_d = DONE;
`ifdef SEQ_ALU_DIV_EN
         DIV: if (lastIter) state_d = DONE;
`endif
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the state.
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
   end

   assign bus.result    = result_q;
   assign bus.flag_zero = zero_q;
   assign bus.flag_ovf  = ovf_q;
   assign bus.flag_neg  = neg_q;
   assign bus.flag_ill  = ill_q;

   // Datapath next values: capture operands on accept, iterate in MUL/DIV, and load the
   // result register once; zero/neg are taken from the exact value being registered.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      negRes_d = negRes_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      load     = 1'b0;
      newRes   = '0;
      newOvf   = 1'b0;
      newIll   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      quo_d      = quo_q;
      rem_d      = rem_q;
      divisor_d  = divisor_q;
      dividend_d = dividend_q;
      isRem_d    = isRem_q;
      divOvf_d   = divOvf_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d = '0;
               load  = 1'b1;
               case (bus.opcode)
                  OP_SLA: begin
                     newRes = {bus.a[WIDTH-2:0], 1'b0};
                     newOvf = bus.a[WIDTH-1] ^ bus.a[WIDTH-2];
                  end
                  OP_SRA: newRes = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
                  OP_ADD: begin
                     newRes = sum;
                     newOvf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                  end
                  OP_SUB: begin
                     newRes = diff;
                     newOvf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
                  end
                  OP_MUL: begin
                     load     = 1'b0;
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, absA};
                     mplier_d = absB;
                     negRes_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  end
                  OP_AND: newRes = bus.a & bus.b;
                  OP_OR:  newRes = bus.a | bus.b;
                  OP_NOT: newRes = ~bus.a;
`ifdef SEQ_ALU_DIV_EN
                  OP_DIV, OP_REM: begin
                     load       = 1'b0;
                     quo_d      = absA;
                     rem_d      = '0;
                     divisor_d  = absB;
                     dividend_d = bus.a;
                     negRes_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                     isRem_d    = (bus.opcode == OP_REM);
                     divOvf_d   = (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
                  end
`endif
                  default: newIll = 1'b1;
               endcase
            end
         end
         MUL: begin
            acc_d    = mulAccNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (lastIter) begin
               load   = 1'b1;
               newRes = mulLow;
               newOvf = mulOvf;
            end
         end
`ifdef SEQ_ALU_DIV_EN
         DIV: begin
            quo_d = quoNext;
            rem_d = remNext;
            cnt_d = cnt_q + CNT_W'(1);
            if (lastIter) begin
               load   = 1'b1;
               newRes = isRem_q ? remOut : quoOut;
               newOvf = divZero | divOvf_q;
            end
         end
`endif
         default: ;
      endcase
      if (load) begin
         result_d = newRes;
         ovf_d    = newOvf;
         ill_d    = newIll;
         zero_d   = (newRes == '0);
         neg_d    = newRes[WIDTH-1];
      end
   end

   // Datapath registers; reset clears results, flags and any captured operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         negRes_q   <= 1'b0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
         ill_q      <= 1'b0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         quo_q      <= '0;
         rem_q      <= '0;
         divisor_q  <= '0;
         dividend_q <= '0;
         isRem_q    <= 1'b0;
         divOvf_q   <= 1'b0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         negRes_q   <= negRes_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
         ill_q      <= ill_d;
         zero_q     <= zero_d;
         neg_q      <= neg_d;
`ifdef SEQ_ALU_DIV_EN
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         divisor_q  <= divisor_d;
         dividend_q <= dividend_d;
         isRem_q    <= isRem_d;
         divOvf_q   <= divOvf_d;
`endif
      end
   end
endmodule
